// File: rtl/console_pkg.sv
// Shared definitions for the text console: screen geometry defaults, control
// codes, FSM state encoding and byte-source tags.
package console_pkg;

  localparam int COLS_DEF = 160;
  localparam int ROWS_DEF = 60;

  localparam int COL_W  = 8;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = ROW_W + COL_W;

  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    ECHO  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_RX = 1'b0,
    SRC_KB = 1'b1
  } src_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= SPACE) && (b <= TILDE);
  endfunction

endpackage

// File: rtl/text_console_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: req[0] = rx, req[1] = keyboard. On a tie the
// requester that was not served last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       ack,
  output logic [1:0] grant
);

  logic last_q;  // 0: rx served last, 1: keyboard served last
  logic last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (ack && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: arbitrates tty and keyboard byte streams, renders
// them into a COLS x ROWS character buffer and echoes keyboard bytes to the tty.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [7:0]        kb_data,
  input  logic              kb_valid,
  output logic              kb_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] vga_waddr,
  output logic [7:0]        vga_wdata,
  output logic              vga_wr_en
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_e             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  src_e               src_q, src_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [ROW_W-1:0]   clr_row_q, clr_row_d;
  logic [COL_W-1:0]   clr_col_q, clr_col_d;
  logic               clr_done_q, clr_done_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               tx_valid_q, tx_valid_d;

  logic [1:0]         grant;
  logic               accept;
  logic [7:0]         in_byte;

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_LAST) ? '0 : r + ROW_W'(1);
  endfunction

  rr_arb2 u_arb (
    .clk   (clk48),
    .rst_n (rst_n),
    .req   ({kb_valid, rx_valid}),
    .ack   (accept),
    .grant (grant)
  );

  always_comb begin
    rx_ready   = (state_q == IDLE) && grant[0];
    kb_ready   = (state_q == IDLE) && grant[1];
    accept     = (rx_valid && rx_ready) || (kb_valid && kb_ready);
    in_byte    = grant[1] ? kb_data : rx_data;

    state_d    = state_q;
    byte_d     = byte_q;
    src_d      = src_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    clr_done_d = clr_done_q;
    wr_en_d    = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      CLEAR: begin
        // The last write is still visible in the final CLEAR cycle, so the
        // strobe never overlaps IDLE.
        if (!clr_done_q) begin
          wr_en_d = 1'b1;
          waddr_d = {clr_row_q, clr_col_q};
          wdata_d = SPACE;
          if (clr_col_q == COL_LAST) begin
            clr_col_d = '0;
            if (clr_row_q == ROW_LAST) begin
              clr_done_d = 1'b1;
            end else begin
              clr_row_d = clr_row_q + ROW_W'(1);
            end
          end else begin
            clr_col_d = clr_col_q + COL_W'(1);
          end
        end else begin
          state_d   = IDLE;
          cur_row_d = '0;
          cur_col_d = '0;
        end
      end

      IDLE: begin
        // Decode at acceptance so the write strobe is registered into EXEC.
        if (accept) begin
          byte_d  = in_byte;
          src_d   = grant[1] ? SRC_KB : SRC_RX;
          state_d = EXEC;
          if (is_printable(in_byte)) begin
            wr_en_d = 1'b1;
            waddr_d = {cur_row_q, cur_col_q};
            wdata_d = in_byte;
            if (cur_col_q == COL_LAST) begin
              cur_col_d = '0;
              cur_row_d = row_inc(cur_row_q);
            end else begin
              cur_col_d = cur_col_q + COL_W'(1);
            end
          end else if (in_byte == CR) begin
            cur_col_d = '0;
          end else if (in_byte == LF) begin
            cur_row_d = row_inc(cur_row_q);
          end else if (in_byte == BS) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - COL_W'(1);
              wr_en_d   = 1'b1;
              waddr_d   = {cur_row_q, cur_col_q - COL_W'(1)};
              wdata_d   = SPACE;
            end
          end else if (in_byte == FF) begin
            cur_row_d = '0;
            cur_col_d = '0;
          end
        end
      end

      EXEC: begin
        if (src_q == SRC_KB) begin
          tx_valid_d = 1'b1;
          state_d    = ECHO;
        end else if (byte_q == FF) begin
          state_d    = CLEAR;
          clr_row_d  = '0;
          clr_col_d  = '0;
          clr_done_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      ECHO: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (byte_q == FF) begin
            state_d    = CLEAR;
            clr_row_d  = '0;
            clr_col_d  = '0;
            clr_done_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      byte_q     <= 8'h00;
      src_q      <= SRC_RX;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      clr_done_q <= 1'b0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      src_q      <= src_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      clr_done_q <= clr_done_d;
      wr_en_q    <= wr_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data   = byte_q;
  assign tx_valid  = tx_valid_q;
  assign vga_waddr = waddr_q;
  assign vga_wdata = wdata_q;
  assign vga_wr_en = wr_en_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: screen clear, cursor movement, arbitration,
// echo back-pressure and reset during clear.
module tb_text_console_ctrl;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data, kb_data, tx_data, vga_wdata;
  logic        rx_valid, rx_ready, kb_valid, kb_ready, tx_valid, tx_ready, vga_wr_en;
  logic [13:0] vga_waddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk48 = ~clk48;

  text_console_ctrl #(.COLS(160), .ROWS(60)) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .kb_data   (kb_data),
    .kb_valid  (kb_valid),
    .kb_ready  (kb_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .vga_waddr (vga_waddr),
    .vga_wdata (vga_wdata),
    .vga_wr_en (vga_wr_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input string tag, input logic [13:0] addr, input logic [7:0] data);
    chk({tag, "_wr_en"}, 32'(vga_wr_en), 32'd1);
    chk({tag, "_addr"},  32'(vga_waddr), 32'(addr));
    chk({tag, "_data"},  32'(vga_wdata), 32'(data));
  endtask

  task automatic exp_nowr(input string tag);
    chk({tag, "_no_wr"}, 32'(vga_wr_en), 32'd0);
  endtask

  // Offers a byte from a negedge; returns at the negedge of the EXEC cycle.
  task automatic send(input bit from_kb, input logic [7:0] b);
    bit got;
    got = 1'b0;
    if (from_kb) begin kb_data = b; kb_valid = 1'b1; end
    else         begin rx_data = b; rx_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      #1;
      if (from_kb ? kb_ready : rx_ready) begin got = 1'b1; break; end
      @(negedge clk48);
    end
    chk("handshake", 32'(got), 32'd1);
    if (got) @(negedge clk48);
    if (from_kb) kb_valid = 1'b0; else rx_valid = 1'b0;
    $display("send %s byte %h", from_kb ? "kb" : "rx", b);
  endtask

  // Counts clear writes until a ready goes high (caller keeps a valid asserted).
  task automatic count_clear(output int n, output logic [13:0] first, output logic [13:0] last,
                             output int bad, output bit seen_idle);
    n = 0; bad = 0; first = '1; last = '1; seen_idle = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk48);
      if (rx_ready || kb_ready) begin seen_idle = 1'b1; break; end
      if (vga_wr_en) begin
        if (n == 0) first = vga_waddr;
        last = vga_waddr;
        n++;
        if (vga_wdata !== 8'h20) bad++;
      end
    end
    $display("clear: %0d writes, first %h last %h", n, first, last);
  endtask

  task automatic check_clear(input string tag);
    int n, bad;
    logic [13:0] first, last;
    bit seen_idle;
    count_clear(n, first, last, bad, seen_idle);
    chk({tag, "_idle"},  32'(seen_idle), 32'd1);
    chk({tag, "_count"}, 32'(n), 32'd9600);
    chk({tag, "_first"}, 32'(first), 32'h0000);
    chk({tag, "_last"},  32'(last), 32'h3B9F);
    chk({tag, "_data"},  32'(bad), 32'd0);
  endtask

  initial begin
    int wcount;
    logic [13:0] wlast;

    rst_n = 1'b0; tx_ready = 1'b1;
    rx_data = 8'h5A; rx_valid = 1'b1;
    kb_data = 8'h62; kb_valid = 1'b1;
    @(posedge clk48); @(posedge clk48); @(negedge clk48);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_kb_ready", 32'(kb_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_wr_en",    32'(vga_wr_en), 32'd0);
    rst_n = 1'b1;

    check_clear("clr0");

    // Both requesters valid at first IDLE: keyboard first, then rx.
    chk("tie_kb_ready", 32'(kb_ready), 32'd1);
    chk("tie_rx_ready", 32'(rx_ready), 32'd0);
    send(1'b1, 8'h62);
    exp_wr("tie_kb", 14'h0000, 8'h62);
    chk("tie_exec_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk48);
    chk("tie_echo_valid", 32'(tx_valid), 32'd1);
    chk("tie_echo_data",  32'(tx_data), 32'h62);
    exp_nowr("tie_echo");
    @(negedge clk48);
    chk("tie_rx_granted", 32'(rx_ready), 32'd1);
    send(1'b0, 8'h5A);
    exp_wr("tie_rx", 14'h0001, 8'h5A);
    chk("tie_rx_no_tx", 32'(tx_valid), 32'd0);

    // Fill row 0 up to column 158, then write at the last column.
    for (int c = 2; c <= 158; c++) begin
      send(1'b0, 8'h2E);
      exp_wr("fill", 14'(c), 8'h2E);
    end
    send(1'b0, 8'h41);
    exp_wr("lastcol", 14'h009F, 8'h41);
    chk("lastcol_no_tx", 32'(tx_valid), 32'd0);
    @(negedge clk48);
    chk("lastcol_idle_no_tx", 32'(tx_valid), 32'd0);
    send(1'b0, 8'h42);
    exp_wr("wrap_col", 14'h0100, 8'h42);

    // CR, LF, LF -> (3,0); backspace at column 0 does nothing.
    send(1'b0, 8'h0D); exp_nowr("cr");
    send(1'b0, 8'h0A); exp_nowr("lf1");
    send(1'b0, 8'h0A); exp_nowr("lf2");
    send(1'b0, 8'h08); exp_nowr("bs_col0");
    send(1'b0, 8'h43); exp_wr("after_bs0", 14'h0300, 8'h43);
    send(1'b0, 8'h08); exp_wr("bs_col1", 14'h0300, 8'h20);
    for (int r = 0; r < 56; r++) send(1'b0, 8'h0A);
    send(1'b0, 8'h47); exp_wr("row59", 14'h3B00, 8'h47);
    send(1'b0, 8'h0D); exp_nowr("cr59");
    send(1'b0, 8'h0A); exp_nowr("lf_wrap");
    send(1'b0, 8'h07); exp_nowr("ignored");
    send(1'b0, 8'h44); exp_wr("row_wrap", 14'h0000, 8'h44);

    // Echo held off by tx_ready for 5 cycles.
    tx_ready = 1'b0;
    send(1'b1, 8'h61);
    exp_wr("kb_a", 14'h0001, 8'h61);
    kb_data = 8'h63; kb_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk48);
      chk("hold_tx_valid", 32'(tx_valid), 32'd1);
      chk("hold_tx_data",  32'(tx_data), 32'h61);
      chk("hold_kb_ready", 32'(kb_ready), 32'd0);
      exp_nowr("hold");
      if (k == 6) tx_ready = 1'b1;
    end
    @(negedge clk48);
    chk("post_echo_tx_valid", 32'(tx_valid), 32'd0);
    chk("post_echo_kb_ready", 32'(kb_ready), 32'd1);
    send(1'b1, 8'h63);
    exp_wr("kb_c", 14'h0002, 8'h63);
    @(negedge clk48);
    chk("kb_c_echo", 32'(tx_data), 32'h63);
    chk("kb_c_valid", 32'(tx_valid), 32'd1);
    @(negedge clk48);
    chk("kb_c_done", 32'(tx_valid), 32'd0);

    // Form feed from rx: full clear, cursor home.
    send(1'b0, 8'h0C); exp_nowr("ff");
    rx_data = 8'h45; rx_valid = 1'b1;
    check_clear("clr_ff");
    send(1'b0, 8'h45); exp_wr("ff_home", 14'h0000, 8'h45);

    // Reset at the 100th clear write restarts the clear from address 0.
    send(1'b0, 8'h0C); exp_nowr("ff2");
    wcount = 0; wlast = '1;
    for (int i = 0; i < 300 && wcount < 100; i++) begin
      @(negedge clk48);
      if (vga_wr_en) begin wcount++; wlast = vga_waddr; end
    end
    chk("clr100_count", 32'(wcount), 32'd100);
    chk("clr100_addr",  32'(wlast), 32'h0063);
    rst_n = 1'b0;
    @(negedge clk48);
    chk("midrst_wr_en",    32'(vga_wr_en), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    rst_n = 1'b1;
    rx_data = 8'h46; rx_valid = 1'b1;
    check_clear("clr_rst");
    send(1'b0, 8'h46); exp_wr("rst_home", 14'h0000, 8'h46);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
